// File: rtl/hc_csr_pkg.sv
// hc_csr_pkg: shared CCI-P MMIO types, HardCloud address map, control codes,
// FSM state enum and the descriptor address classifier used by hc_csr_ctrl.
package hc_csr_pkg;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  localparam logic [15:0] HC_DSM_BYTE     = 16'h110;
  localparam logic [15:0] HC_CONTROL_BYTE = 16'h118;
  localparam logic [15:0] HC_BUF_STRIDE   = 16'h10;
  localparam logic [15:0] HC_MMIO_WORDS   = 16'h100;
  typedef enum logic [2:0] {
    HC_CTRL_ASSERT_RST   = 3'd0,
    HC_CTRL_DEASSERT_RST = 3'd1,
    HC_CTRL_START        = 3'd3,
    HC_CTRL_STOP         = 3'd7
  } t_hc_control;
  typedef logic [63:0] t_hc_address;
  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } t_hc_state;
  typedef struct packed {
    logic       valid;
    logic [3:0] index;
    logic       is_size;
  } t_hc_buf_sel;
  typedef struct packed {
    logic        dsm;
    logic        control;
    t_hc_buf_sel buf_sel;
  } t_hc_decode;
  // Word-address classifier for the descriptor window. Each descriptor spans
  // four words: address at offset 0, size at offset 2; odd words are holes.
  function automatic t_hc_buf_sel hc_buf_index(input logic [15:0] addr,
                                               input logic [15:0] base = 16'h120,
                                               input logic [4:0]  num = 5'd2);
    logic [15:0] off;
    t_hc_buf_sel sel;
    off = addr - (base >> 2);
    sel.valid = addr >= (base >> 2) && off < {9'b0, num, 2'b00} && !off[0];
    sel.index = off[5:2];
    sel.is_size = off[1];
    return sel;
  endfunction
endpackage

// File: rtl/hc_csr_decode.sv
// hc_csr_decode: classifies an MMIO word address into dsm / control /
// descriptor (index, is_size) / unmapped. Feeds the single register stage in
// hc_csr_ctrl so a request at cycle N takes effect at N+1.
// Ports: addr (MMIO word address), dec (classification).
module hc_csr_decode
  import hc_csr_pkg::*;
#(
  parameter int          NUM_BUFFERS = 2,
  parameter logic [15:0] BUF_BASE    = 16'h120
) (
  input  logic [15:0] addr,
  output t_hc_decode  dec
);
  logic        in_range;
  t_hc_buf_sel sel;
  assign in_range = addr < HC_MMIO_WORDS;
  assign sel = hc_buf_index(addr, BUF_BASE, 5'(NUM_BUFFERS));
  assign dec.dsm = in_range && addr == (HC_DSM_BYTE >> 2);
  assign dec.control = in_range && addr == (HC_CONTROL_BYTE >> 2);
  assign dec.buf_sel = '{valid: in_range && sel.valid, index: sel.index, is_size: sel.is_size};
endmodule

// File: rtl/hc_csr_ctrl.sv
// hc_csr_ctrl: HardCloud CSR file and accelerator control FSM on CCI-P MMIO.
// Ports: clk, rst_n (async active-low); mmio_rx (c0 MMIO requests);
// mmio_tx (c2 read responses); dsm_base, buffers (registered CSRs);
// afu_reset/afu_start/afu_running/afu_stop (datapath control); afu_done.
// Define HC_CSR_READBACK_EN to build the MMIO read response path; without it
// mmio_tx is tied to zero and reads are ignored.
module hc_csr_ctrl
  import hc_csr_pkg::*;
#(
  parameter int          NUM_BUFFERS = 2,
  parameter logic [15:0] BUF_BASE    = 16'h120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  t_if_ccip_c0_Rx mmio_rx,
  output t_if_ccip_c2_Tx mmio_tx,
  output logic [63:0]    dsm_base,
  output t_hc_buffer     buffers [NUM_BUFFERS],
  output logic           afu_reset,
  output logic           afu_start,
  output logic           afu_running,
  output logic           afu_stop,
  input  logic           afu_done
);
  t_ccip_c0_ReqMmioHdr hdr;
  t_hc_decode          dec;
  t_hc_state           state, nxt;
  logic                wr_err;
  logic [63:0]         wdata;
  logic                wr, ctrl_wr, data_wr, busy;
  logic                is_rst, is_deassert, is_start, is_stop;
  logic                unused_bits;
  assign hdr = t_ccip_c0_ReqMmioHdr'(mmio_rx.hdr);
  assign wdata = mmio_rx.data[63:0];
  hc_csr_decode #(.NUM_BUFFERS(NUM_BUFFERS), .BUF_BASE(BUF_BASE)) u_decode (
    .addr(hdr.address),
    .dec (dec)
  );
  assign wr = mmio_rx.mmioWrValid;
  // Only exact 64-bit control codes are honoured; stray upper bits void the write.
  assign ctrl_wr = wr && dec.control && wdata[63:3] == '0;
  assign is_rst = ctrl_wr && wdata[2:0] == HC_CTRL_ASSERT_RST;
  assign is_deassert = ctrl_wr && wdata[2:0] == HC_CTRL_DEASSERT_RST;
  assign is_start = ctrl_wr && wdata[2:0] == HC_CTRL_START;
  assign is_stop = ctrl_wr && wdata[2:0] == HC_CTRL_STOP;
  assign data_wr = wr && (dec.dsm || dec.buf_sel.valid);
  assign busy = state == S_RUN || state == S_STOP;
  // afu_done takes priority over a same-cycle STOP in S_RUN.
  always_comb
    nxt = is_rst ? S_RESET
        : state == S_RESET && is_deassert ? S_IDLE
        : (state == S_IDLE || state == S_DONE) && is_start ? S_RUN
        : busy && afu_done ? S_DONE
        : state == S_RUN && is_stop ? S_STOP
        : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RESET;
      wr_err <= 1'b0;
      afu_start <= 1'b0;
      dsm_base <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) buffers[i] <= '0;
    end else begin
      state <= nxt;
      afu_start <= nxt == S_RUN && !busy;
      wr_err <= is_rst ? 1'b0 : wr_err || (data_wr && busy);
      if (data_wr && !busy && dec.dsm) dsm_base <= wdata;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (data_wr && !busy && dec.buf_sel.valid && dec.buf_sel.index == 4'(i)) begin
          if (dec.buf_sel.is_size) buffers[i].size <= wdata[31:0];
          else buffers[i].address <= wdata;
        end
      end
    end
  assign afu_reset = state == S_RESET;
  assign afu_running = busy;
  assign afu_stop = state == S_STOP;
`ifdef HC_CSR_READBACK_EN
  logic [63:0] rd_buf, rd_data;
  always_comb begin
    rd_buf = '0;
    for (int i = 0; i < NUM_BUFFERS; i++)
      if (dec.buf_sel.index == 4'(i))
        rd_buf = dec.buf_sel.is_size ? {32'b0, buffers[i].size} : buffers[i].address;
  end
  assign rd_data = dec.dsm ? dsm_base
                 : dec.control ? {56'b0, wr_err, 4'b0, state}
                 : dec.buf_sel.valid ? rd_buf
                 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mmio_tx <= '0;
    else begin
      mmio_tx.mmioRdValid <= mmio_rx.mmioRdValid;
      mmio_tx.hdr.tid <= hdr.tid;
      mmio_tx.data <= rd_data;
    end
  assign unused_bits = ^{hdr.length, hdr.rsvd, mmio_rx.data[511:64], mmio_rx.rspValid};
`else
  assign mmio_tx = '0;
  assign unused_bits = ^{hdr.length, hdr.rsvd, hdr.tid, mmio_rx.data[511:64],
                         mmio_rx.rspValid, mmio_rx.mmioRdValid};
`endif
endmodule

// File: tb/tb_hc_csr_ctrl.sv
// tb_hc_csr_ctrl: directed self-checking bench for hc_csr_ctrl (NUM_BUFFERS=4).
module tb_hc_csr_ctrl;
  import hc_csr_pkg::*;
  logic           clk = 1'b0;
  logic           rst_n;
  t_if_ccip_c0_Rx mmio_rx;
  t_if_ccip_c2_Tx mmio_tx;
  logic [63:0]    dsm_base;
  t_hc_buffer     buffers [4];
  logic           afu_reset, afu_start, afu_running, afu_stop, afu_done;
  int             total = 0;
  int             bad = 0;
  int             rv_seen = 0;
  always #5 clk = ~clk;
  hc_csr_ctrl #(.NUM_BUFFERS(4), .BUF_BASE(16'h120)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mmio_rx    (mmio_rx),
    .mmio_tx    (mmio_tx),
    .dsm_base   (dsm_base),
    .buffers    (buffers),
    .afu_reset  (afu_reset),
    .afu_start  (afu_start),
    .afu_running(afu_running),
    .afu_stop   (afu_stop),
    .afu_done   (afu_done)
  );
  always @(negedge clk) if (mmio_tx.mmioRdValid) rv_seen++;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = a >> 2;
    mmio_rx.hdr = h;
    mmio_rx.data = 512'(d);
    mmio_rx.mmioWrValid = 1'b1;
    @(negedge clk);
    mmio_rx.mmioWrValid = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [8:0] tid);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = a >> 2;
    h.tid = tid;
    mmio_rx.hdr = h;
    mmio_rx.mmioRdValid = 1'b1;
    @(negedge clk);
    mmio_rx.mmioRdValid = 1'b0;
  endtask
  initial begin
    mmio_rx = '0;
    afu_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_afu_reset", 96'(afu_reset), 96'd1);
    chk("rst_ctl", 96'({afu_start, afu_running, afu_stop}), 96'd0);
    chk("rst_dsm", 96'(dsm_base), 96'd0);
    chk("rst_buf3", buffers[3], 96'd0);
    chk("rst_tx", 96'(mmio_tx), 96'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wr(16'h118, 64'd1);
    chk("deassert_rst", 96'(afu_reset), 96'd0);
`ifdef HC_CSR_READBACK_EN
    rd(16'h118, 9'd3);
    chk("status_idle", 96'({mmio_tx.mmioRdValid, mmio_tx.hdr.tid, mmio_tx.data}), {23'd0, 1'b1, 9'd3, 64'h1});
`endif
    wr(16'h150, 64'hDEAD_0000);
    wr(16'h158, 64'h400);
    chk("buf3", buffers[3], {64'hDEAD_0000, 32'h400});
    wr(16'h160, 64'h5555);
    chk("unmapped_buf3", buffers[3], {64'hDEAD_0000, 32'h400});
    chk("unmapped_buf0", buffers[0], 96'd0);
    wr(16'h128, 64'hFFFF_FFFF_0000_0011);
    wr(16'h124, 64'h77);
    chk("buf0_size_low32", buffers[0], {64'd0, 32'h11});
    wr(16'h110, 64'h1234_5678_9ABC_DEF0);
    chk("dsm_write", 96'(dsm_base), 96'(64'h1234_5678_9ABC_DEF0));
    wr(16'h510, 64'h1);
    chk("dsm_out_of_range", 96'(dsm_base), 96'(64'h1234_5678_9ABC_DEF0));
`ifdef HC_CSR_READBACK_EN
    rd(16'h110, 9'd9);
    chk("rd_dsm", 96'({mmio_tx.mmioRdValid, mmio_tx.hdr.tid, mmio_tx.data}), {23'd0, 1'b1, 9'd9, 64'h1234_5678_9ABC_DEF0});
    rd(16'h150, 9'd1);
    chk("rd_buf3_addr", 96'({mmio_tx.mmioRdValid, mmio_tx.hdr.tid, mmio_tx.data}), {23'd0, 1'b1, 9'd1, 64'hDEAD_0000});
    rd(16'h160, 9'd2);
    chk("rd_unmapped", 96'({mmio_tx.mmioRdValid, mmio_tx.hdr.tid, mmio_tx.data}), {23'd0, 1'b1, 9'd2, 64'h0});
    @(negedge clk);
    chk("rd_single_pulse", 96'(mmio_tx.mmioRdValid), 96'd0);
`endif
    wr(16'h118, 64'd3);
    chk("start_pulse", 96'({afu_start, afu_running}), 96'b11);
    @(negedge clk);
    chk("start_one_cycle", 96'({afu_start, afu_running}), 96'b01);
    wr(16'h110, 64'h1);
    chk("dsm_protected", 96'(dsm_base), 96'(64'h1234_5678_9ABC_DEF0));
    wr(16'h150, 64'h0);
    chk("buf_protected", buffers[3], {64'hDEAD_0000, 32'h400});
`ifdef HC_CSR_READBACK_EN
    rd(16'h118, 9'd4);
    chk("status_run_err", 96'(mmio_tx.data), 96'h82);
`endif
    wr(16'h118, 64'd3);
    chk("start_in_run", 96'(afu_start), 96'd0);
    wr(16'h118, 64'd7);
    chk("stop", 96'({afu_stop, afu_running}), 96'b11);
    afu_done = 1'b1;
    @(negedge clk);
    afu_done = 1'b0;
    chk("done_from_stop", 96'({afu_stop, afu_running, afu_reset}), 96'b000);
    wr(16'h118, 64'd3);
    chk("restart", 96'({afu_start, afu_running}), 96'b11);
    afu_done = 1'b1;
    wr(16'h118, 64'd7);
    afu_done = 1'b0;
    chk("done_beats_stop", 96'({afu_stop, afu_running}), 96'b00);
    @(negedge clk);
    chk("stop_discarded", 96'({afu_stop, afu_running}), 96'b00);
    wr(16'h118, 64'd7);
    chk("stop_in_done", 96'(afu_stop), 96'd0);
    wr(16'h110, 64'hCAFE);
    chk("dsm_after_done", 96'(dsm_base), 96'(64'hCAFE));
`ifdef HC_CSR_READBACK_EN
    rd(16'h118, 9'd5);
    chk("status_done_err", 96'(mmio_tx.data), 96'h84);
`endif
    wr(16'h118, 64'h1_0000_0003);
    chk("bad_ctrl_upper", 96'({afu_start, afu_running}), 96'b00);
    wr(16'h118, 64'd2);
    chk("bad_ctrl_2", 96'({afu_start, afu_running, afu_reset}), 96'b000);
    wr(16'h118, 64'd0);
    chk("assert_rst", 96'(afu_reset), 96'd1);
`ifdef HC_CSR_READBACK_EN
    rd(16'h118, 9'd6);
    chk("status_reset_clr", 96'(mmio_tx.data), 96'h0);
`endif
    wr(16'h118, 64'd3);
    chk("start_in_reset", 96'({afu_start, afu_running, afu_reset}), 96'b001);
    wr(16'h118, 64'd1);
    wr(16'h118, 64'd3);
    chk("rerun", 96'(afu_running), 96'd1);
    rd(16'h158, 9'd7);
`ifdef HC_CSR_READBACK_EN
    chk("rd_size_in_run", 96'({mmio_tx.mmioRdValid, mmio_tx.hdr.tid, mmio_tx.data}), {23'd0, 1'b1, 9'd7, 64'h400});
`else
    chk("no_readback_tx", 96'(mmio_tx), 96'd0);
    chk("no_rd_valid_seen", 96'(rv_seen), 96'd0);
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 96'({afu_running, afu_reset, afu_stop}), 96'b010);
    chk("async_rst_regs", 96'({dsm_base, buffers[3].size}), 96'd0);
    chk("async_rst_buf3", buffers[3], 96'd0);
    chk("async_rst_tx", 96'(mmio_tx), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
